// File: rtl/ctrl_decode_pipe_if.sv
// ctrl_decode_pipe_if: fetch/decode/execute handshake plus the registered control bundle
interface ctrl_decode_pipe_if #(parameter int DATA_W = 16);
  logic if_valid, id_ready, flush, ex_ready, ex_valid;
  logic [15:0] instr;
  logic [3:0] rs_addr, rt_addr, dst, alu_op;
  logic reg_write, mem_read, mem_write, mem_to_reg;
  logic alu_src_imm, branch, branch_reg, llb, lhb, pcs, hlt, halted;
  logic [2:0] branch_cond;
  logic [DATA_W-1:0] imm;
  modport master(
    output if_valid, instr, flush, ex_ready,
    input id_ready, ex_valid, rs_addr, rt_addr, dst, alu_op, reg_write, mem_read, mem_write,
    mem_to_reg, alu_src_imm, branch, branch_reg, llb, lhb, pcs, hlt, halted, branch_cond, imm
  );
  modport slave(
    input if_valid, instr, flush, ex_ready,
    output id_ready, ex_valid, rs_addr, rt_addr, dst, alu_op, reg_write, mem_read, mem_write,
    mem_to_reg, alu_src_imm, branch, branch_reg, llb, lhb, pcs, hlt, halted, branch_cond, imm
  );
endinterface

// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe: registered WISC-S25 decode stage with load-use stall, flush and HLT drain
module ctrl_decode_pipe #(
  parameter int DATA_W     = 16,
  parameter int HALT_DRAIN = 4
) (
  input logic clk,
  input logic rst,
  ctrl_decode_pipe_if.slave bus
);
  localparam int CW = HALT_DRAIN > 1 ? $clog2(HALT_DRAIN) : 1;
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
  typedef struct packed {
    logic [3:0] dst;
    logic reg_write, mem_read, mem_write, mem_to_reg;
    logic [3:0] alu_op;
    logic alu_src_imm, branch, branch_reg, llb, lhb, pcs, hlt;
    logic [2:0] branch_cond;
    logic [DATA_W-1:0] imm;
  } bundle_t;
  state_t state_q;
  logic [CW-1:0] cnt_q;
  logic halted_q, ex_valid_d, ex_valid_q;
  bundle_t dec, slot_d, slot_q;
  logic [3:0] op, rd, rs, rt;
  logic is_lw, is_sw, is_llb, is_lhb, use_rs, use_rt, use_rd, hazard, adv, ready, acc;
  assign op = bus.instr[15:12];
  assign rd = bus.instr[11:8];
  assign rs = bus.instr[7:4];
  assign rt = bus.instr[3:0];
  assign is_lw = op == 4'h8;
  assign is_sw = op == 4'h9;
  assign is_llb = op == 4'hA;
  assign is_lhb = op == 4'hB;
  assign bus.rs_addr = rs;
  assign bus.rt_addr = (is_lw | is_sw | is_llb | is_lhb) ? rd : rt;
  assign use_rs = op <= 4'h9 || op == 4'hD;
  assign use_rt = op <= 4'h3 || op == 4'h7;
  assign use_rd = is_sw | is_llb | is_lhb;
  assign hazard = ex_valid_q & slot_q.mem_read &
                  ((use_rs & slot_q.dst == rs) | (use_rt & slot_q.dst == rt) | (use_rd & slot_q.dst == rd));
  assign adv = !ex_valid_q | bus.ex_ready;
  assign ready = !rst & state_q == RUN & adv & !hazard;
  assign acc = bus.if_valid & ready;
  assign bus.id_ready = ready;
  // decode the presented instruction into a control bundle
  always_comb begin
    dec = '0;
    dec.reg_write = op <= 4'h8 || is_llb || is_lhb || op == 4'hE;
    dec.dst = dec.reg_write ? rd : 4'h0;
    dec.alu_op = op <= 4'h7 ? op : 4'h0;
    dec.alu_src_imm = op inside {4'h4, 4'h5, 4'h6, 4'h8, 4'h9};
    dec.mem_read = is_lw;
    dec.mem_to_reg = is_lw;
    dec.mem_write = is_sw;
    dec.branch = op == 4'hC || op == 4'hD;
    dec.branch_reg = op == 4'hD;
    dec.llb = is_llb;
    dec.lhb = is_lhb;
    dec.pcs = op == 4'hE;
    dec.hlt = op == 4'hF;
    dec.branch_cond = dec.branch ? bus.instr[11:9] : 3'h0;
    dec.imm = op inside {4'h4, 4'h5, 4'h6} ? {{(DATA_W-4){1'b0}}, rt} :
              (is_lw | is_sw) ? {{(DATA_W-4){rt[3]}}, rt[2:0], 1'b0} :
              (is_llb | is_lhb) ? {{(DATA_W-8){1'b0}}, bus.instr[7:0]} :
              op == 4'hC ? {{(DATA_W-9){bus.instr[8]}}, bus.instr[7:0], 1'b0} : '0;
  end
  // flush kills the slot, an accepted instruction loads it, an advancing slot bubbles
  always_comb begin
    ex_valid_d = bus.flush ? 1'b0 : acc ? 1'b1 : adv ? 1'b0 : ex_valid_q;
    slot_d = (!bus.flush && acc) ? dec : slot_q;
  end
  // issue slot registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      slot_q <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      slot_q <= slot_d;
    end
  end
  // halt sequencing: an accepted HLT drains for HALT_DRAIN cycles unless flushed as wrong-path
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q <= '0;
      halted_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: if (acc && !bus.flush && op == 4'hF) begin
          state_q <= DRAIN;
          cnt_q <= CW'(HALT_DRAIN - 1);
        end
        DRAIN: if (bus.flush) begin
          state_q <= RUN;
          cnt_q <= '0;
        end else if (cnt_q == '0) begin
          state_q <= HALTED;
          halted_q <= 1'b1;
        end else cnt_q <= cnt_q - 1'b1;
        default: state_q <= HALTED;
      endcase
    end
  end
  assign bus.ex_valid = ex_valid_q;
  assign bus.dst = slot_q.dst;
  assign bus.reg_write = slot_q.reg_write;
  assign bus.mem_read = slot_q.mem_read;
  assign bus.mem_write = slot_q.mem_write;
  assign bus.mem_to_reg = slot_q.mem_to_reg;
  assign bus.alu_op = slot_q.alu_op;
  assign bus.alu_src_imm = slot_q.alu_src_imm;
  assign bus.branch = slot_q.branch;
  assign bus.branch_reg = slot_q.branch_reg;
  assign bus.llb = slot_q.llb;
  assign bus.lhb = slot_q.lhb;
  assign bus.pcs = slot_q.pcs;
  assign bus.hlt = slot_q.hlt;
  assign bus.branch_cond = slot_q.branch_cond;
  assign bus.imm = slot_q.imm;
  assign bus.halted = halted_q;
endmodule

// File: tb/tb_ctrl_decode_pipe.sv
// tb_ctrl_decode_pipe: randomized and directed checks of the decode stage against a behavioural model
module tb_ctrl_decode_pipe;
  localparam int DW = 16;
  localparam int HD = 4;
  typedef struct packed {
    logic [3:0] dst;
    logic reg_write, mem_read, mem_write, mem_to_reg;
    logic [3:0] alu_op;
    logic alu_src_imm, branch, branch_reg, llb, lhb, pcs, hlt;
    logic [2:0] branch_cond;
    logic [DW-1:0] imm;
  } bun_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int errors = 0;
  int checks = 0;
  bit m_valid, m_halted, m_drain;
  int m_left;
  bun_t m_b;
  ctrl_decode_pipe_if #(.DATA_W(DW)) bus();
  ctrl_decode_pipe #(.DATA_W(DW), .HALT_DRAIN(HD)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic bun_t ref_dec(logic [15:0] i);
    bun_t b;
    int op, v;
    b = '0;
    op = int'(i[15:12]);
    if (op inside {[0:8], 10, 11, 14}) begin
      b.reg_write = 1'b1;
      b.dst = i[11:8];
    end
    if (op <= 7) b.alu_op = i[15:12];
    b.alu_src_imm = op inside {4, 5, 6, 8, 9};
    b.mem_read = op == 8;
    b.mem_to_reg = op == 8;
    b.mem_write = op == 9;
    b.branch = op == 12 || op == 13;
    b.branch_reg = op == 13;
    b.llb = op == 10;
    b.lhb = op == 11;
    b.pcs = op == 14;
    b.hlt = op == 15;
    if (b.branch) b.branch_cond = i[11:9];
    if (op inside {4, 5, 6}) b.imm = DW'(i[3:0]);
    if (op inside {8, 9}) begin
      v = i[3] ? int'(i[3:0]) - 16 : int'(i[3:0]);
      b.imm = DW'(v * 2);
    end
    if (op inside {10, 11}) b.imm = DW'(i[7:0]);
    if (op == 12) begin
      v = i[8] ? int'(i[8:0]) - 512 : int'(i[8:0]);
      b.imm = DW'(v * 2);
    end
    return b;
  endfunction

  function automatic bit uses(logic [15:0] i, logic [3:0] r);
    case (i[15:12])
      4'h0, 4'h1, 4'h2, 4'h3, 4'h7: return r == i[7:4] || r == i[3:0];
      4'h4, 4'h5, 4'h6, 4'h8, 4'hD: return r == i[7:4];
      4'h9: return r == i[7:4] || r == i[11:8];
      4'hA, 4'hB: return r == i[11:8];
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit exp_ready();
    return !rst && !m_drain && !m_halted && (!m_valid || bus.ex_ready)
           && !(m_valid && m_b.mem_read && uses(bus.instr, m_b.dst));
  endfunction

  function automatic bun_t dut_b();
    return bun_t'({bus.dst, bus.reg_write, bus.mem_read, bus.mem_write, bus.mem_to_reg, bus.alu_op,
                   bus.alu_src_imm, bus.branch, bus.branch_reg, bus.llb, bus.lhb, bus.pcs, bus.hlt,
                   bus.branch_cond, bus.imm});
  endfunction

  task automatic tick();
    bit acc;
    acc = bus.if_valid && exp_ready();
    @(posedge clk);
    if (rst) begin
      m_valid = 0; m_b = '0; m_halted = 0; m_drain = 0; m_left = 0;
    end else begin
      if (!m_halted && m_drain) begin
        if (bus.flush) m_drain = 0;
        else begin
          m_left--;
          if (m_left == 0) begin m_drain = 0; m_halted = 1; end
        end
      end else if (!m_halted && acc && !bus.flush && bus.instr[15:12] == 4'hF) begin
        m_drain = 1; m_left = HD;
      end
      if (bus.flush) m_valid = 0;
      else if (acc) begin m_valid = 1; m_b = ref_dec(bus.instr); end
      else if (!m_valid || bus.ex_ready) m_valid = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1; bus.if_valid = 0; bus.flush = 0; bus.ex_ready = 1; bus.instr = 16'h0;
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; bus.if_valid = 1; bus.instr = 16'h0123; bus.ex_ready = 1; bus.flush = 0;
    #1;
    checks++;
    if (bus.id_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b want=0", bus.id_ready); end
    tick(); tick();
    checks++;
    if (dut_b() !== '0 || bus.ex_valid !== 1'b0 || bus.halted !== 1'b0) begin
      errors++; $display("FAIL reset_state got=%h/%b/%b want=0/0/0", dut_b(), bus.ex_valid, bus.halted);
    end
    rst = 0; bus.if_valid = 0;
    #1;
    checks++;
    if (bus.id_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b want=1", bus.id_ready); end
  endtask

  task automatic test_add_stream();
    do_reset();
    bus.if_valid = 1; bus.ex_ready = 1; bus.instr = 16'h0123;
    tick();
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.alu_op !== 4'h0 || bus.dst !== 4'h1 || bus.reg_write !== 1'b1) begin
      errors++; $display("FAIL add1 got v=%b op=%h dst=%h rw=%b want 1/0/1/1", bus.ex_valid, bus.alu_op, bus.dst, bus.reg_write);
    end
    bus.instr = 16'h1456;
    #1;
    checks++;
    if (bus.id_ready !== 1'b1) begin errors++; $display("FAIL add2_ready got=%b want=1", bus.id_ready); end
    tick();
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.alu_op !== 4'h1 || bus.dst !== 4'h4 || bus.reg_write !== 1'b1) begin
      errors++; $display("FAIL add2 got v=%b op=%h dst=%h rw=%b want 1/1/4/1", bus.ex_valid, bus.alu_op, bus.dst, bus.reg_write);
    end
    bus.if_valid = 0;
  endtask

  task automatic test_immediates();
    do_reset();
    bus.if_valid = 1; bus.ex_ready = 1; bus.instr = 16'h812F;
    #1;
    checks++;
    if (bus.rt_addr !== 4'h1 || bus.rs_addr !== 4'h2) begin
      errors++; $display("FAIL lw_addr got rs=%h rt=%h want rs=2 rt=1", bus.rs_addr, bus.rt_addr);
    end
    tick();
    checks++;
    if (bus.imm !== 16'hFFFE || bus.mem_read !== 1'b1 || bus.dst !== 4'h1 || bus.mem_to_reg !== 1'b1) begin
      errors++; $display("FAIL lw_imm got imm=%h mr=%b dst=%h want FFFE/1/1", bus.imm, bus.mem_read, bus.dst);
    end
    bus.instr = 16'hC1FF;
    tick();
    checks++;
    if (bus.imm !== 16'hFFFE || bus.branch_cond !== 3'h0 || bus.branch !== 1'b1 || bus.reg_write !== 1'b0) begin
      errors++; $display("FAIL b_imm got imm=%h cond=%h br=%b want FFFE/0/1", bus.imm, bus.branch_cond, bus.branch);
    end
    bus.instr = 16'hA3A5;
    tick();
    checks++;
    if (bus.imm !== 16'h00A5 || bus.llb !== 1'b1 || bus.dst !== 4'h3) begin
      errors++; $display("FAIL llb_imm got imm=%h llb=%b dst=%h want 00A5/1/3", bus.imm, bus.llb, bus.dst);
    end
    bus.if_valid = 0;
  endtask

  task automatic test_load_use();
    do_reset();
    bus.if_valid = 1; bus.ex_ready = 1; bus.instr = 16'h8120;
    tick();
    bus.instr = 16'h0412;
    #1;
    checks++;
    if (bus.id_ready !== 1'b0) begin errors++; $display("FAIL lu_stall_ready got=%b want=0", bus.id_ready); end
    tick();
    checks++;
    if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got ex_valid=%b want=0", bus.ex_valid); end
    #1;
    checks++;
    if (bus.id_ready !== 1'b1) begin errors++; $display("FAIL lu_resume_ready got=%b want=1", bus.id_ready); end
    tick();
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.alu_op !== 4'h0 || bus.dst !== 4'h4 || bus.mem_read !== 1'b0) begin
      errors++; $display("FAIL lu_issue got v=%b op=%h dst=%h want 1/0/4", bus.ex_valid, bus.alu_op, bus.dst);
    end
    bus.if_valid = 0;
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.if_valid = 1; bus.ex_ready = 1; bus.instr = 16'h2345;
    tick();
    bus.ex_ready = 0; bus.instr = 16'h3567;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (bus.id_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got=%b want=0", k, bus.id_ready); end
      tick();
      checks++;
      if (bus.ex_valid !== 1'b1 || bus.alu_op !== 4'h2 || bus.dst !== 4'h3) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b op=%h dst=%h want 1/2/3", k, bus.ex_valid, bus.alu_op, bus.dst);
      end
    end
    bus.ex_ready = 1;
    tick();
    checks++;
    if (bus.ex_valid !== 1'b1 || bus.alu_op !== 4'h3 || bus.dst !== 4'h5) begin
      errors++; $display("FAIL bp_release got v=%b op=%h dst=%h want 1/3/5", bus.ex_valid, bus.alu_op, bus.dst);
    end
    bus.if_valid = 0;
  endtask

  task automatic test_halt();
    do_reset();
    bus.if_valid = 1; bus.ex_ready = 1; bus.instr = 16'hF000;
    tick();
    checks++;
    if (bus.hlt !== 1'b1 || bus.ex_valid !== 1'b1 || bus.halted !== 1'b0) begin
      errors++; $display("FAIL halt_issue got hlt=%b v=%b halted=%b want 1/1/0", bus.hlt, bus.ex_valid, bus.halted);
    end
    bus.instr = 16'h0123;
    for (int k = 1; k <= 7; k++) begin
      bus.flush = k == 6;
      #1;
      checks++;
      if (bus.id_ready !== 1'b0) begin errors++; $display("FAIL halt_ready[E+%0d] got=%b want=0", k, bus.id_ready); end
      tick();
      checks++;
      if (bus.halted !== (k >= HD) || bus.halted !== m_halted) begin
        errors++; $display("FAIL halt_flag[E+%0d] got=%b want=%b", k, bus.halted, k >= HD);
      end
    end
    bus.flush = 0; bus.if_valid = 0;
  endtask

  task automatic test_flush_drain();
    do_reset();
    bus.if_valid = 1; bus.ex_ready = 1; bus.instr = 16'hF000; bus.flush = 1;
    tick();
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.id_ready !== 1'b1) begin
      errors++; $display("FAIL flush_hlt_same got v=%b ready=%b want 0/1", bus.ex_valid, bus.id_ready);
    end
    bus.flush = 0;
    tick();
    bus.if_valid = 0;
    tick();
    bus.flush = 1;
    tick();
    bus.flush = 0;
    #1;
    checks++;
    if (bus.ex_valid !== 1'b0 || bus.halted !== 1'b0 || bus.id_ready !== 1'b1) begin
      errors++; $display("FAIL flush_drain got v=%b halted=%b ready=%b want 0/0/1", bus.ex_valid, bus.halted, bus.id_ready);
    end
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if (bus.halted !== 1'b0) begin errors++; $display("FAIL flush_drain_late got halted=%b want=0", bus.halted); end
  endtask

  task automatic test_rst_drain();
    do_reset();
    bus.if_valid = 1; bus.ex_ready = 1; bus.instr = 16'hF000;
    tick();
    bus.if_valid = 0;
    tick(); tick();
    rst = 1;
    #1;
    checks++;
    if (bus.id_ready !== 1'b0) begin errors++; $display("FAIL rst_drain_ready got=%b want=0", bus.id_ready); end
    tick();
    rst = 0;
    #1;
    checks++;
    if (dut_b() !== '0 || bus.ex_valid !== 1'b0 || bus.halted !== 1'b0 || bus.id_ready !== 1'b1) begin
      errors++; $display("FAIL rst_drain got b=%h v=%b halted=%b ready=%b want 0/0/0/1", dut_b(), bus.ex_valid, bus.halted, bus.id_ready);
    end
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (bus.halted !== 1'b0) begin errors++; $display("FAIL rst_drain_late got halted=%b want=0", bus.halted); end
  endtask

  task automatic test_random();
    logic [3:0] op;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      op = 4'($urandom_range(0, 14));
      bus.instr = {op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
      bus.if_valid = $urandom_range(0, 3) != 0;
      bus.ex_ready = $urandom_range(0, 3) != 0;
      bus.flush = $urandom_range(0, 19) == 0;
      #1;
      checks++;
      if (bus.id_ready !== exp_ready()) begin
        errors++; $display("FAIL rand_ready[%0d] got=%b want=%b instr=%h", c, bus.id_ready, exp_ready(), bus.instr);
      end
      checks++;
      if (bus.rt_addr !== (op inside {4'h8, 4'h9, 4'hA, 4'hB} ? bus.instr[11:8] : bus.instr[3:0]) && op != 4'hD) begin
        errors++; $display("FAIL rand_rt_addr[%0d] got=%h instr=%h", c, bus.rt_addr, bus.instr);
      end
      if (!(op inside {4'h8, 4'h9, 4'hA, 4'hB})) begin
        checks++;
        if (bus.rs_addr !== bus.instr[7:4]) begin
          errors++; $display("FAIL rand_rs_addr[%0d] got=%h want=%h", c, bus.rs_addr, bus.instr[7:4]);
        end
      end
      tick();
      checks++;
      if (dut_b() !== m_b || bus.ex_valid !== m_valid || bus.halted !== m_halted) begin
        errors++; $display("FAIL rand_slot[%0d] got=%h/%b/%b want=%h/%b/%b", c, dut_b(), bus.ex_valid, bus.halted, m_b, m_valid, m_halted);
      end
    end
    bus.if_valid = 0; bus.flush = 0;
  endtask

  initial begin
    bus.if_valid = 0; bus.flush = 0; bus.ex_ready = 1; bus.instr = 16'h0;
    m_valid = 0; m_halted = 0; m_drain = 0; m_left = 0; m_b = '0;
    test_reset();
    test_add_stream();
    test_immediates();
    test_load_use();
    test_backpressure();
    test_halt();
    test_flush_drain();
    test_rst_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
